// File: rtl/adapter_high_perf.sv
`default_nettype none
// ============================================================================
// Module  : adapter_high_perf
// Brief   : Low-res opcode/stream responder that sequences the high-perf
//           Dilithium core through KEYGEN and VERIFY commands.
// Rev     : 1.0  initial release
// ============================================================================
module adapter_high_perf #(
    parameter int SEED_WORDS = 8,
    parameter int PK_WORDS   = 328,
    parameter int SK_WORDS   = 640,
    parameter int SIG_WORDS  = 605
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  op_in,
    input  logic        op_valid_in,
    output logic        ready_out,
    input  logic [31:0] data_in,
    input  logic        valid_in,
    output logic        ready_rcv_out,
    output logic [31:0] data_out,
    output logic        valid_out,
    input  logic        ready_rcv_in,
    output logic        err,
    output logic        hp_start,
    output logic [1:0]  hp_mode,
    output logic [31:0] hp_data_i,
    output logic        hp_valid_i,
    input  logic        hp_ready_i,
    input  logic [31:0] hp_data_o,
    input  logic        hp_valid_o,
    output logic        hp_ready_o,
    input  logic        hp_done
);

    localparam logic [3:0] c_OP_STOR_SEED = 4'b1111;
    localparam logic [3:0] c_OP_STOR_PK   = 4'b1100;
    localparam logic [3:0] c_OP_STOR_SIG  = 4'b1110;
    localparam logic [3:0] c_OP_KGEN      = 4'b0111;
    localparam logic [3:0] c_OP_LOAD_SK   = 4'b1001;
    localparam logic [3:0] c_OP_LOAD_PK   = 4'b1000;
    localparam logic [3:0] c_OP_PRECOMP   = 4'b0101;
    localparam logic [3:0] c_OP_DIGEST    = 4'b0001;
    localparam logic [3:0] c_OP_VRFY      = 4'b0100;

    localparam logic [4:0] c_S_IDLE       = 5'd0;
    localparam logic [4:0] c_S_KG_SEED    = 5'd1;
    localparam logic [4:0] c_S_KG_W_KGEN  = 5'd2;
    localparam logic [4:0] c_S_KG_EXEC    = 5'd3;
    localparam logic [4:0] c_S_KG_W_LSK   = 5'd4;
    localparam logic [4:0] c_S_KG_DUMP_SK = 5'd5;
    localparam logic [4:0] c_S_KG_W_LPK   = 5'd6;
    localparam logic [4:0] c_S_KG_DUMP_PK = 5'd7;
    localparam logic [4:0] c_S_VF_PK      = 5'd8;
    localparam logic [4:0] c_S_VF_W_SIG   = 5'd9;
    localparam logic [4:0] c_S_VF_SIG     = 5'd10;
    localparam logic [4:0] c_S_VF_W_PRE   = 5'd11;
    localparam logic [4:0] c_S_VF_W_DIG   = 5'd12;
    localparam logic [4:0] c_S_VF_LEN     = 5'd13;
    localparam logic [4:0] c_S_VF_MSG     = 5'd14;
    localparam logic [4:0] c_S_VF_W_VRFY  = 5'd15;
    localparam logic [4:0] c_S_VF_EXEC    = 5'd16;
    localparam logic [4:0] c_S_VF_RESULT  = 5'd17;

    logic [4:0]  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        start_q, start_d;
    logic [1:0]  mode_q, mode_d;
    logic        result_q, result_d;
    logic        done_seen_q, done_seen_d;

    logic        w_op_ready;
    logic        w_op_acc;
    logic        w_in_hs;
    logic        w_out_hs;
    logic        w_cnt_last;
    logic [32:0] w_len_sum;
    logic [31:0] w_msg_words;

    assign w_op_ready = (state_q inside {c_S_IDLE, c_S_KG_W_KGEN, c_S_KG_W_LSK,
                                         c_S_KG_W_LPK, c_S_VF_W_SIG, c_S_VF_W_PRE,
                                         c_S_VF_W_DIG, c_S_VF_W_VRFY});
    assign w_op_acc    = op_valid_in & w_op_ready;
    assign w_in_hs     = valid_in & hp_ready_i;
    assign w_out_hs    = hp_valid_o & ready_rcv_in;
    assign w_cnt_last  = (cnt_q == 32'd1);
    // Byte length rounded up to words; 33 bits so L near 2^32 cannot wrap.
    assign w_len_sum   = {1'b0, data_in} + 33'd3;
    assign w_msg_words = 32'(w_len_sum >> 2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= c_S_IDLE;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            start_q     <= 1'b0;
            mode_q      <= 2'd0;
            result_q    <= 1'b0;
            done_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            start_q     <= start_d;
            mode_q      <= mode_d;
            result_q    <= result_d;
            done_seen_q <= done_seen_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        start_d     = 1'b0;
        mode_d      = mode_q;
        result_d    = result_q;
        done_seen_d = done_seen_q;
        case (state_q)
            c_S_IDLE: if (w_op_acc) begin
                if (op_in == c_OP_STOR_SEED) begin
                    start_d = 1'b1;
                    mode_d  = 2'd0;
                    cnt_d   = 32'(SEED_WORDS);
                    state_d = c_S_KG_SEED;
                end else if (op_in == c_OP_STOR_PK) begin
                    start_d = 1'b1;
                    mode_d  = 2'd1;
                    cnt_d   = 32'(PK_WORDS);
                    state_d = c_S_VF_PK;
                end else begin
                    err_d = 1'b1;
                end
            end
            c_S_KG_SEED: if (w_in_hs) begin
                cnt_d = cnt_q - 32'd1;
                if (w_cnt_last) state_d = c_S_KG_W_KGEN;
            end
            c_S_KG_W_KGEN: if (w_op_acc) begin
                if (op_in == c_OP_KGEN) state_d = c_S_KG_EXEC;
                else err_d = 1'b1;
            end
            // First sk word is only observed here; the dump state consumes it.
            c_S_KG_EXEC: if (hp_valid_o) state_d = c_S_KG_W_LSK;
            c_S_KG_W_LSK: if (w_op_acc) begin
                if (op_in == c_OP_LOAD_SK) begin
                    cnt_d   = 32'(SK_WORDS);
                    state_d = c_S_KG_DUMP_SK;
                end else begin
                    err_d = 1'b1;
                end
            end
            c_S_KG_DUMP_SK: if (w_out_hs) begin
                cnt_d = cnt_q - 32'd1;
                if (w_cnt_last) state_d = c_S_KG_W_LPK;
            end
            c_S_KG_W_LPK: if (w_op_acc) begin
                if (op_in == c_OP_LOAD_PK) begin
                    cnt_d       = 32'(PK_WORDS);
                    done_seen_d = 1'b0;
                    state_d     = c_S_KG_DUMP_PK;
                end else begin
                    err_d = 1'b1;
                end
            end
            c_S_KG_DUMP_PK: begin
                if (hp_done) done_seen_d = 1'b1;
                if (w_out_hs) begin
                    cnt_d = cnt_q - 32'd1;
                    if (w_cnt_last) begin
                        state_d = c_S_IDLE;
                        if (!(done_seen_q | hp_done)) err_d = 1'b1;
                    end
                end
            end
            c_S_VF_PK: if (w_in_hs) begin
                cnt_d = cnt_q - 32'd1;
                if (w_cnt_last) state_d = c_S_VF_W_SIG;
            end
            c_S_VF_W_SIG: if (w_op_acc) begin
                if (op_in == c_OP_STOR_SIG) begin
                    cnt_d   = 32'(SIG_WORDS);
                    state_d = c_S_VF_SIG;
                end else begin
                    err_d = 1'b1;
                end
            end
            c_S_VF_SIG: if (w_in_hs) begin
                cnt_d = cnt_q - 32'd1;
                if (w_cnt_last) state_d = c_S_VF_W_PRE;
            end
            c_S_VF_W_PRE: if (w_op_acc) begin
                if (op_in == c_OP_PRECOMP) state_d = c_S_VF_W_DIG;
                else err_d = 1'b1;
            end
            c_S_VF_W_DIG: if (w_op_acc) begin
                if (op_in == c_OP_DIGEST) begin
                    cnt_d   = 32'd1;
                    state_d = c_S_VF_LEN;
                end else begin
                    err_d = 1'b1;
                end
            end
            c_S_VF_LEN: if (w_in_hs) begin
                cnt_d   = w_msg_words;
                state_d = (w_msg_words == 32'd0) ? c_S_VF_W_VRFY : c_S_VF_MSG;
            end
            c_S_VF_MSG: if (w_in_hs) begin
                cnt_d = cnt_q - 32'd1;
                if (w_cnt_last) state_d = c_S_VF_W_VRFY;
            end
            c_S_VF_W_VRFY: if (w_op_acc) begin
                if (op_in == c_OP_VRFY) state_d = c_S_VF_EXEC;
                else err_d = 1'b1;
            end
            c_S_VF_EXEC: if (hp_valid_o) begin
                result_d = hp_data_o[0];
                state_d  = c_S_VF_RESULT;
            end
            c_S_VF_RESULT: if (ready_rcv_in) state_d = c_S_IDLE;
            default: state_d = c_S_IDLE;
        endcase
    end

    always_comb begin
        ready_out     = w_op_ready;
        ready_rcv_out = 1'b0;
        hp_data_i     = '0;
        hp_valid_i    = 1'b0;
        data_out      = '0;
        valid_out     = 1'b0;
        hp_ready_o    = 1'b0;
        case (state_q)
            c_S_KG_SEED, c_S_VF_PK, c_S_VF_SIG, c_S_VF_LEN, c_S_VF_MSG: begin
                hp_data_i     = data_in;
                hp_valid_i    = valid_in;
                ready_rcv_out = hp_ready_i;
            end
            c_S_KG_DUMP_SK, c_S_KG_DUMP_PK: begin
                data_out   = hp_data_o;
                valid_out  = hp_valid_o;
                hp_ready_o = ready_rcv_in;
            end
            c_S_VF_EXEC: hp_ready_o = 1'b1;
            c_S_VF_RESULT: begin
                valid_out = 1'b1;
                data_out  = {31'b0, result_q};
            end
            default: ;
        endcase
    end

    assign err      = err_q;
    assign hp_start = start_q;
    assign hp_mode  = mode_q;

endmodule
`default_nettype wire

// File: doc/adapter_high_perf.md
# adapter_high_perf

Command responder presenting the low-res Dilithium core's opcode/stream interface to a low-res host and executing each command on the high-perf Dilithium core. Decodes 4-bit opcodes, starts the high-perf core in the right mode, and forwards 32-bit words between the two streaming interfaces. It enforces the KEYGEN and VERIFY command sequences, counts words per payload, and returns the verify result as one word.

## Interface
- SEED_WORDS, 8: seed payload length in 32-bit words.
- PK_WORDS, 328: public key length in words.
- SK_WORDS, 640: secret key length in words.
- SIG_WORDS, 605: signature length in words.
- clk  in  1  clock.
- rst  in  1  reset; one clock, asynchronous, active-high.
- op_in  in  4  host opcode.
- op_valid_in  in  1  opcode valid; accepted when op_valid_in & ready_out.
- ready_out  out  1  ready for the next opcode (level).
- data_in / valid_in / ready_rcv_out  in / in / out  32/1/1  host-to-core word stream.
- data_out / valid_out / ready_rcv_in  out / out / in  32/1/1  core-to-host word stream.
- err  out  1  sticky illegal-opcode flag; cleared only by rst.
- hp_start, hp_mode  out  1, 2  high-perf start pulse and mode (0 keygen, 1 verify).
- hp_data_i / hp_valid_i / hp_ready_i  out / out / in  32/1/1  stream into the high-perf core.
- hp_data_o / hp_valid_o / hp_ready_o  in / in / out  32/1/1  stream out of the high-perf core.
- hp_done  in  1  high-perf done; ignored except in KG_DUMP_PK.

## Operation
- Opcodes:
  - STOR_SEED 1111, STOR_PK 1100, STOR_SIG 1110.
  - KGEN 0111, LOAD_SK 1001, LOAD_PK 1000.
  - VRFY_PRECOMP 0101, DIGEST_MSG 0001, VRFY 0100.
- Keygen sequence:
  - IDLE, on STOR_SEED: pulse hp_start one cycle with hp_mode=0, then go to KG_SEED.
  - KG_SEED: forward SEED_WORDS words, then wait for KGEN.
  - KG_EXEC: hold ready_out low until hp_valid_o=1. Do not consume that word.
  - Wait for LOAD_SK, then KG_DUMP_SK: forward SK_WORDS words.
  - Wait for LOAD_PK, then KG_DUMP_PK: forward PK_WORDS words, then return to IDLE.
  - The high-perf core emits sk words before pk words.
- Verify sequence:
  - IDLE, on STOR_PK: pulse hp_start with hp_mode=1, then go to VF_PK.
  - VF_PK: forward PK_WORDS words.
  - Wait for STOR_SIG, then VF_SIG: forward SIG_WORDS words.
  - Wait for VRFY_PRECOMP; it has no payload and completes in 1 cycle.
  - Wait for DIGEST_MSG, then VF_LEN: forward 1 length word L (bytes).
  - VF_MSG: forward ceil(L/4) words, computed as (L+3)>>2 in 33 bits. When L=0 there are no message words.
  - Wait for VRFY, then VF_EXEC: on hp_valid_o, latch hp_data_o[0] with hp_ready_o=1 that cycle.
  - VF_RESULT: drive valid_out=1 and data_out={31'b0,result}; go to IDLE on ready_rcv_in.
- Inbound streaming states: hp_data_i=data_in, hp_valid_i=valid_in, ready_rcv_out=hp_ready_i. In all other states hp_valid_i=0 and ready_rcv_out=0.
- Outbound dump states: data_out=hp_data_o, valid_out=hp_valid_o, hp_ready_o=ready_rcv_in. In all other states valid_out=0 and hp_ready_o=0, except VF_EXEC and VF_RESULT as above.
- Word counter: 32-bit down-counter, loaded on op accept (on the length handshake for VF_MSG). It decrements on each handshake. The state exits on the handshake that takes it from 1 to 0.
- ready_out=1 only in IDLE and wait-for-op states.
- Illegal opcode in the current state: the opcode is consumed, err is set, and state is unchanged. An illegal opcode never pulses hp_start.

## Timing
- Reset values: ready_out=1, err=0, hp_start=0, hp_mode=0, all valid/ready outputs 0, data_out=0, counter 0, state IDLE.
- Opcode accept takes 1 cycle. Streaming is enabled from the next cycle.
- Forwarding is combinational, with zero added latency and full throughput (1 word/cycle).
- The cycle after the last payload handshake: ready_out=1.
- Backpressure on either side stalls without loss or duplication.
- rst asserted mid-stream: immediately IDLE, outputs at reset values, no further words forwarded.
- After LOAD_PK completes, hp_done must be high. Absent it, err is set and state still returns to IDLE.

## Test plan
- Keygen: STOR_SEED, 8 seed words, KGEN, LOAD_SK, LOAD_PK -> hp_start pulses once with mode 0; 640 then 328 words reach data_out in order; ready_out=1 after each phase; err=0.
- Verify, L=5: STOR_PK (328), STOR_SIG (605), VRFY_PRECOMP, DIGEST_MSG with length 5 plus 2 words, VRFY; core returns 1 -> data_out=0x00000001, valid_out held until ready_rcv_in.
- Verify, L=0 with core result 0 -> no message words accepted after the length word; data_out=0x00000000.
- Illegal: VRFY issued from IDLE -> err=1, hp_start never pulses, ready_out stays 1; a following STOR_SEED is still accepted.
- Backpressure: random valid_in / hp_ready_i / ready_rcv_in gaps during VF_SIG and KG_DUMP_SK -> exact word counts, no duplicates.
- Reset after word 100 of the PK in VF_PK -> all outputs at reset values within the same cycle; STOR_PK afterwards restarts from word 0.
